array_div_issue_capture: RTL and testbench
==========================================

Name: array_div_issue_capture

Overview:
- Sequential front/back end for the 16/8 combinational array divider row (the approximate array-divider variants).
- Accepts a dividend/divisor pair over a valid/ready handshake and holds it stable on the array inputs.
- Waits a parameterised number of settle cycles for the array's ripple-borrow path, then captures q/r and presents them downstream with divide-by-zero and overflow flags.

Parameters:
- SETTLE_CYCLES, 2, cycles from operand launch to result capture; legal range 1..15.
- N_W, 16, dividend width; fixed at 2*D_W.
- D_W, 8, divisor, quotient and remainder width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_n  input  N_W  dividend
- in_d  input  D_W  divisor
- div_n  output  N_W  registered dividend to array n
- div_d  output  D_W  registered divisor to array d
- div_q  input  D_W  array quotient
- div_r  input  D_W  array remainder
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_q  output  D_W  captured quotient
- out_r  output  D_W  captured remainder
- out_dbz  output  1  divisor was zero
- out_ovf  output  1  exact quotient exceeds D_W bits
- busy  output  1  state != IDLE

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n, synchronous, active-low.
- Reset, sampled at a clk edge with rst_n=0:
  - state=IDLE.
  - div_n, div_d, out_q, out_r = 0.
  - out_valid, out_dbz, out_ovf, busy = 0.
  - settle counter = 0.
  - Reset wins over any concurrent handshake. Reset mid-SETTLE or mid-DONE discards the operation; no result is emitted.
- in_ready = (state==IDLE), combinational from the state register.
- No overlap: at most one operation in flight.
- IDLE, on in_valid & in_ready at edge k:
  - div_n<=in_n, div_d<=in_d.
  - dbz_r<=(in_d==0).
  - ovf_r<=(in_d!=0) & (in_n[N_W-1:D_W] >= in_d).
  - If dbz: go directly to DONE at edge k with out_q<=all-ones, out_r<=in_n[D_W-1:0], out_dbz<=1, out_ovf<=0. out_valid is visible in cycle k+1.
  - Else: go to SETTLE with counter<=SETTLE_CYCLES-1.
- SETTLE:
  - Counter decrements each edge.
  - When counter==0 at an edge: out_q<=div_q, out_r<=div_r, out_dbz<=0, out_ovf<=ovf_r, then go to DONE.
  - Capture occurs at edge k+SETTLE_CYCLES; out_valid is high from the following cycle.
- DONE:
  - out_valid=1; out_q, out_r and flags are held stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE, out_valid<=0. out_q/out_r retain their last values.
  - in_ready first rises in the cycle after the output handshake.
- div_n/div_d hold their value until the next accept; they never change during SETTLE.
- Overflow case: the array's q/r are captured unmodified; only the flag is raised.
- Array outputs are not checked for correctness; approximate cells are the array's concern.
- Widths: the comparison is unsigned and D_W wide. There is no arithmetic beyond that comparison.

Decomposition:
- Shared package/header holds:
  - state encoding: IDLE=2'd0, SETTLE=2'd1, DONE=2'd2.
  - DBZ_QUOTIENT constant (all-ones).
  - default SETTLE_CYCLES.
- No sub-module is needed. The array divider is instantiated by the parent alongside this block, not inside it, so array variants can be swapped.

Test Plan:
1. Bench array model drives div_q/div_r = exact n/d, valid only from edge launch+SETTLE_CYCLES, X before that. Issue n=100, d=7, SETTLE_CYCLES=2 -> out_valid exactly 3 cycles after accept; out_q=14, out_r=2, out_dbz=0, out_ovf=0.
2. n=16'h1234, d=0 -> out_valid the cycle after accept; out_q=8'hFF, out_r=8'h34, out_dbz=1, out_ovf=0; div_q is ignored.
3. n=16'h0900, d=8 -> out_ovf=1; out_q/out_r equal whatever the model drives on div_q/div_r at the capture edge.
4. out_ready held low for 5 cycles in DONE -> out_valid and data stable all 5 cycles. in_ready=0 throughout. in_valid asserted during DONE is not accepted; it is accepted in the first IDLE cycle.
5. Assert rst_n=0 for one edge during SETTLE -> all outputs 0 and state IDLE the next cycle; no out_valid pulse. A new operation is then accepted normally.
6. Back-to-back: in_valid held high, out_ready held high, SETTLE_CYCLES=1, pairs (255,3), (65535,255), (0,5) -> results (85,0), ovf=1, (0,0) in order, each accept 3 cycles apart.

Source files
------------

// File: rtl/array_div_issue_capture_pkg.sv
// Shared constants for the array divider issue/capture front end.
package array_div_issue_capture_pkg;

   // Controller state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Default geometry and timing of the 16/8 array row
   localparam int D_W_DEFAULT           = 8;
   localparam int SETTLE_CYCLES_DEFAULT = 2;

   // Quotient reported when the divisor is zero (all ones at default width)
   localparam logic [D_W_DEFAULT-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/array_div_issue_capture.sv
// Launches an operand pair onto an external combinational array divider,
// waits for the ripple-borrow path to settle, then captures and presents
// the quotient/remainder with divide-by-zero and overflow flags.
module array_div_issue_capture
   import array_div_issue_capture_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
   parameter int D_W           = D_W_DEFAULT,
   parameter int N_W           = 2 * D_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_W-1:0] in_n,
   input  logic [D_W-1:0] in_d,
   output logic [N_W-1:0] div_n,
   output logic [D_W-1:0] div_d,
   input  logic [D_W-1:0] div_q,
   input  logic [D_W-1:0] div_r,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [D_W-1:0] out_q,
   output logic [D_W-1:0] out_r,
   output logic           out_dbz,
   output logic           out_ovf,
   output logic           busy
);

   // Full-width all-ones quotient for the divide-by-zero result
   localparam logic [D_W-1:0] DBZ_Q = {D_W{1'b1}};
   localparam logic [3:0]     CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   logic [1:0]     state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [N_W-1:0] div_n_q, div_n_d;
   logic [D_W-1:0] div_d_q, div_d_d;
   logic           ovf_r_q, ovf_r_d;
   logic [D_W-1:0] out_q_q, out_q_d;
   logic [D_W-1:0] out_r_q, out_r_d;
   logic           out_dbz_q, out_dbz_d;
   logic           out_ovf_q, out_ovf_d;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign div_n     = div_n_q;
   assign div_d     = div_d_q;
   assign out_q     = out_q_q;
   assign out_r     = out_r_q;
   assign out_dbz   = out_dbz_q;
   assign out_ovf   = out_ovf_q;

   // Next-state logic: accept, settle countdown, capture, output handshake
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_n_d   = div_n_q;
      div_d_d   = div_d_q;
      ovf_r_d   = ovf_r_q;
      out_q_d   = out_q_q;
      out_r_d   = out_r_q;
      out_dbz_d = out_dbz_q;
      out_ovf_d = out_ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               div_n_d = in_n;
               div_d_d = in_d;
               // Quotient fits in D_W bits only if the high half is below the divisor
               ovf_r_d = (in_d != '0) && (in_n[N_W-1:D_W] >= in_d);
               if (in_d == '0) begin
                  // Nothing to wait for: the array result is meaningless here
                  state_d   = ST_DONE;
                  out_q_d   = DBZ_Q;
                  out_r_d   = in_n[D_W-1:0];
                  out_dbz_d = 1'b1;
                  out_ovf_d = 1'b0;
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 4'd0) begin
               // Array outputs are taken as-is, even when the quotient overflowed
               out_q_d   = div_q;
               out_r_d   = div_r;
               out_dbz_d = 1'b0;
               out_ovf_d = ovf_r_q;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         div_n_q   <= '0;
         div_d_q   <= '0;
         ovf_r_q   <= 1'b0;
         out_q_q   <= '0;
         out_r_q   <= '0;
         out_dbz_q <= 1'b0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_n_q   <= div_n_d;
         div_d_q   <= div_d_d;
         ovf_r_q   <= ovf_r_d;
         out_q_q   <= out_q_d;
         out_r_q   <= out_r_d;
         out_dbz_q <= out_dbz_d;
         out_ovf_q <= out_ovf_d;
      end
   end

endmodule

// File: tb/tb_array_div_issue_capture.sv
// Directed bench for array_div_issue_capture: two instances (settle 2 and 1),
// each driven by a behavioural array model that is X until settled.
`timescale 1ns/1ps
module tb_array_div_issue_capture;

   localparam int SA = 2;
   localparam int SB = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A signals
   logic        in_valid_a = 1'b0, out_ready_a = 1'b0;
   logic [15:0] in_n_a = '0;
   logic [7:0]  in_d_a = '0;
   logic        in_ready_a, out_valid_a, out_dbz_a, out_ovf_a, busy_a;
   logic [15:0] div_n_a;
   logic [7:0]  div_d_a, div_q_a, div_r_a, out_q_a, out_r_a;

   // Instance B signals
   logic        in_valid_b = 1'b0, out_ready_b = 1'b0;
   logic [15:0] in_n_b = '0;
   logic [7:0]  in_d_b = '0;
   logic        in_ready_b, out_valid_b, out_dbz_b, out_ovf_b, busy_b;
   logic [15:0] div_n_b;
   logic [7:0]  div_d_b, div_q_b, div_r_b, out_q_b, out_r_b;

   int n_checks = 0;
   int n_pass = 0;

   array_div_issue_capture #(.SETTLE_CYCLES(SA), .D_W(8), .N_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_n(in_n_a), .in_d(in_d_a), .div_n(div_n_a), .div_d(div_d_a),
      .div_q(div_q_a), .div_r(div_r_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_q(out_q_a), .out_r(out_r_a),
      .out_dbz(out_dbz_a), .out_ovf(out_ovf_a), .busy(busy_a));

   array_div_issue_capture #(.SETTLE_CYCLES(SB), .D_W(8), .N_W(16)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_n(in_n_b), .in_d(in_d_b), .div_n(div_n_b), .div_d(div_d_b),
      .div_q(div_q_b), .div_r(div_r_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_q(out_q_b), .out_r(out_r_b),
      .out_dbz(out_dbz_b), .out_ovf(out_ovf_b), .busy(busy_b));

   // Array models: exact n/d, X until SETTLE-1 edges after launch
   logic [3:0] age_a = 4'hF, age_b = 4'hF;
   always @(posedge clk) begin
      if (in_valid_a && in_ready_a) age_a <= 4'd0;
      else if (age_a != 4'hF)       age_a <= age_a + 4'd1;
      if (in_valid_b && in_ready_b) age_b <= 4'd0;
      else if (age_b != 4'hF)       age_b <= age_b + 4'd1;
   end

   logic [15:0] qa_full, ra_full, qb_full, rb_full;
   always_comb begin
      qa_full = 'x; ra_full = 'x; qb_full = 'x; rb_full = 'x;
      if (div_d_a != 8'd0) begin
         qa_full = div_n_a / {8'd0, div_d_a};
         ra_full = div_n_a % {8'd0, div_d_a};
      end
      if (div_d_b != 8'd0) begin
         qb_full = div_n_b / {8'd0, div_d_b};
         rb_full = div_n_b % {8'd0, div_d_b};
      end
   end
   assign div_q_a = (int'(age_a) >= SA - 1) ? qa_full[7:0] : 8'hxx;
   assign div_r_a = (int'(age_a) >= SA - 1) ? ra_full[7:0] : 8'hxx;
   assign div_q_b = (int'(age_b) >= SB - 1) ? qb_full[7:0] : 8'hxx;
   assign div_r_b = (int'(age_b) >= SB - 1) ? rb_full[7:0] : 8'hxx;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair on A for exactly one edge (A must be idle)
   task automatic accept_a(input logic [15:0] n, input logic [7:0] d);
      in_n_a = n; in_d_a = d; in_valid_a = 1'b1;
      tick();
      in_valid_a = 1'b0;
   endtask

   // Complete the output handshake on A
   task automatic release_a();
      out_ready_a = 1'b1;
      tick();
      out_ready_a = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      n_checks++;
      if ({div_n_a, div_d_a, out_q_a, out_r_a, out_valid_a, out_dbz_a, out_ovf_a, busy_a} !== 44'd0)
         $display("FAIL reset_outputs: got n=%h d=%h q=%h r=%h v=%b z=%b o=%b b=%b want all 0",
                  div_n_a, div_d_a, out_q_a, out_r_a, out_valid_a, out_dbz_a, out_ovf_a, busy_a);
      else n_pass++;
      n_checks++;
      if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready_a);
      else n_pass++;
      n_checks++;
      if ({out_valid_b, busy_b, in_ready_b} !== 3'b001)
         $display("FAIL reset_b: got v/busy/rdy=%b want 001", {out_valid_b, busy_b, in_ready_b});
      else n_pass++;
      rst_n = 1'b1;
      tick();
      $display("txn reset done");
   endtask

   task automatic test_basic();
      accept_a(16'd100, 8'd7);
      n_checks++;
      if ({busy_a, in_ready_a, out_valid_a, div_n_a, div_d_a} !== {3'b100, 16'd100, 8'd7})
         $display("FAIL basic_launch: got busy=%b rdy=%b v=%b n=%0d d=%0d want 1 0 0 100 7",
                  busy_a, in_ready_a, out_valid_a, div_n_a, div_d_a);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid_a !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid_a);
      else n_pass++;
      tick();
      n_checks++;
      if ({out_valid_a, out_q_a, out_r_a, out_dbz_a, out_ovf_a} !== {1'b1, 8'd14, 8'd2, 2'b00})
         $display("FAIL basic_result: got v=%b q=%0d r=%0d z=%b o=%b want 1 14 2 0 0",
                  out_valid_a, out_q_a, out_r_a, out_dbz_a, out_ovf_a);
      else n_pass++;
      release_a();
      n_checks++;
      if ({out_valid_a, in_ready_a, busy_a, out_q_a} !== {3'b010, 8'd14})
         $display("FAIL basic_release: got v=%b rdy=%b busy=%b q=%0d want 0 1 0 14",
                  out_valid_a, in_ready_a, busy_a, out_q_a);
      else n_pass++;
      $display("txn basic n=100 d=7 q=%0d r=%0d", out_q_a, out_r_a);
   endtask

   task automatic test_dbz();
      accept_a(16'h1234, 8'd0);
      n_checks++;
      if ({out_valid_a, out_q_a, out_r_a, out_dbz_a, out_ovf_a} !== {1'b1, 8'hFF, 8'h34, 2'b10})
         $display("FAIL dbz_result: got v=%b q=%h r=%h z=%b o=%b want 1 ff 34 1 0",
                  out_valid_a, out_q_a, out_r_a, out_dbz_a, out_ovf_a);
      else n_pass++;
      release_a();
      $display("txn dbz n=1234 d=0 q=%h r=%h", out_q_a, out_r_a);
   endtask

   task automatic test_ovf();
      accept_a(16'h0900, 8'd8);
      tick(); tick();
      n_checks++;
      if ({out_valid_a, out_q_a, out_r_a, out_dbz_a, out_ovf_a} !== {1'b1, 8'h20, 8'h00, 2'b01})
         $display("FAIL ovf_result: got v=%b q=%h r=%h z=%b o=%b want 1 20 00 0 1",
                  out_valid_a, out_q_a, out_r_a, out_dbz_a, out_ovf_a);
      else n_pass++;
      release_a();
      $display("txn ovf n=0900 d=8 q=%h ovf=%b", out_q_a, out_ovf_a);
   endtask

   task automatic test_hold();
      accept_a(16'd300, 8'd10);
      tick(); tick();
      in_n_a = 16'd50; in_d_a = 8'd5; in_valid_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({out_valid_a, in_ready_a, out_q_a, out_r_a, div_n_a} !== {2'b10, 8'd30, 8'd0, 16'd300})
            $display("FAIL hold_cycle%0d: got v=%b rdy=%b q=%0d r=%0d n=%0d want 1 0 30 0 300",
                     i, out_valid_a, in_ready_a, out_q_a, out_r_a, div_n_a);
         else n_pass++;
         tick();
      end
      out_ready_a = 1'b1;
      tick();
      out_ready_a = 1'b0;
      n_checks++;
      if ({in_ready_a, out_valid_a, div_n_a} !== {2'b10, 16'd300})
         $display("FAIL hold_idle: got rdy=%b v=%b n=%0d want 1 0 300", in_ready_a, out_valid_a, div_n_a);
      else n_pass++;
      tick();
      in_valid_a = 1'b0;
      n_checks++;
      if ({busy_a, div_n_a, div_d_a} !== {1'b1, 16'd50, 8'd5})
         $display("FAIL hold_accept: got busy=%b n=%0d d=%0d want 1 50 5", busy_a, div_n_a, div_d_a);
      else n_pass++;
      tick(); tick();
      n_checks++;
      if ({out_valid_a, out_q_a, out_r_a} !== {1'b1, 8'd10, 8'd0})
         $display("FAIL hold_second: got v=%b q=%0d r=%0d want 1 10 0", out_valid_a, out_q_a, out_r_a);
      else n_pass++;
      release_a();
      $display("txn hold n=300 d=10 then n=50 d=5 q=%0d", out_q_a);
   endtask

   task automatic test_reset_mid();
      logic seen_valid;
      accept_a(16'd1000, 8'd9);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++;
      if ({div_n_a, div_d_a, out_q_a, out_r_a, out_valid_a, out_dbz_a, out_ovf_a, busy_a, in_ready_a} !== 45'd1)
         $display("FAIL midreset_outputs: got n=%h d=%h q=%h r=%h v=%b busy=%b rdy=%b want zeros, rdy=1",
                  div_n_a, div_d_a, out_q_a, out_r_a, out_valid_a, busy_a, in_ready_a);
      else n_pass++;
      seen_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid_a !== 1'b0) seen_valid = 1'b1;
         tick();
      end
      n_checks++;
      if (seen_valid !== 1'b0) $display("FAIL midreset_no_pulse: got out_valid=1 want 0");
      else n_pass++;
      accept_a(16'd1000, 8'd9);
      tick(); tick();
      n_checks++;
      if ({out_valid_a, out_q_a, out_r_a} !== {1'b1, 8'd111, 8'd1})
         $display("FAIL midreset_reissue: got v=%b q=%0d r=%0d want 1 111 1", out_valid_a, out_q_a, out_r_a);
      else n_pass++;
      release_a();
      $display("txn midreset then n=1000 d=9 q=%0d r=%0d", out_q_a, out_r_a);
   endtask

   task automatic test_back_to_back();
      logic [15:0] ns [3];
      logic [7:0]  ds [3];
      logic [7:0]  eq [3];
      logic [7:0]  er [3];
      logic        eo [3];
      ns = '{16'd255, 16'd65535, 16'd0};
      ds = '{8'd3, 8'd255, 8'd5};
      eq = '{8'd85, 8'd1, 8'd0};
      er = '{8'd0, 8'd0, 8'd0};
      eo = '{1'b0, 1'b1, 1'b0};
      out_ready_b = 1'b1;
      in_valid_b  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_n_b = ns[i]; in_d_b = ds[i];
         n_checks++;
         if (in_ready_b !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready_b);
         else n_pass++;
         tick();
         n_checks++;
         if ({busy_b, div_n_b, div_d_b} !== {1'b1, ns[i], ds[i]})
            $display("FAIL b2b_accept%0d: got busy=%b n=%0d d=%0d want 1 %0d %0d",
                     i, busy_b, div_n_b, div_d_b, ns[i], ds[i]);
         else n_pass++;
         tick();
         n_checks++;
         if ({out_valid_b, out_q_b, out_r_b, out_ovf_b, in_ready_b} !== {1'b1, eq[i], er[i], eo[i], 1'b0})
            $display("FAIL b2b_result%0d: got v=%b q=%0d r=%0d o=%b rdy=%b want 1 %0d %0d %b 0",
                     i, out_valid_b, out_q_b, out_r_b, out_ovf_b, in_ready_b, eq[i], er[i], eo[i]);
         else n_pass++;
         $display("txn b2b%0d n=%0d d=%0d q=%0d r=%0d ovf=%b", i, ns[i], ds[i], out_q_b, out_r_b, out_ovf_b);
         if (i == 2) in_valid_b = 1'b0;
         tick();
      end
      out_ready_b = 1'b0;
      n_checks++;
      if ({busy_b, out_valid_b} !== 2'b00) $display("FAIL b2b_drain: got busy/v=%b want 00", {busy_b, out_valid_b});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dbz();
      test_ovf();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
